// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared definitions for the alu_md block and its bench.
//   - 5-bit operation codes (single-cycle class 0..9, iterative class 16..23)
//   - state_t: control FSM states, also exported on the debug state port
//   - is_iter_op(): op-class decode (1 = multiply/divide family)
package alu_md_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [4:0] op);
        logic r;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_md_muldiv.sv
// muldiv_iter: iterative multiply / restoring divide, one bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin an XLEN-cycle operation
//   op              operation code (iterative class only)
//   a, b            operands (multiplier/multiplicand, dividend/divisor)
//   done            high in the last of the XLEN working cycles
//   res_hi, res_lo  sign-corrected result, valid while done is high:
//                   multiply -> upper/lower product half,
//                   divide   -> remainder / quotient
// The core always works on unsigned magnitudes; signed variants negate
// the operands on entry and the result on exit.
module muldiv_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);

    logic            busy;
    logic [SHW-1:0]  cnt;
    logic            div_mode;
    logic            neg_res;   // negate product (mul) or quotient (div)
    logic            neg_rem;   // remainder takes the dividend's sign
    logic [XLEN-1:0] mcand;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi;        // partial product high half / remainder
    logic [XLEN-1:0] lo;        // multiplier bits / quotient bits

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_c;

    // Operand sign handling at start
    always_comb begin
        a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg = a_sgn & a[XLEN-1];
        b_neg = b_sgn & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration step
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        rem_shift = {hi, lo[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, mcand};
        if (div_mode) begin
            // Remainder is always below the divisor, so both branches fit XLEN bits
            if (!rem_diff[XLEN]) begin
                step_hi = rem_diff[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = rem_shift[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            // {carry, sum, multiplier} shifted right by one
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Result presented from the final step so the caller can register it
    // on the same edge the last step would be stored.
    always_comb begin
        prod   = {step_hi, step_lo};
        prod_c = neg_res ? -prod : prod;
        if (div_mode) begin
            res_hi = neg_rem ? -step_hi : step_hi;
            res_lo = neg_res ? -step_lo : step_lo;
        end else begin
            res_hi = prod_c[2*XLEN-1:XLEN];
            res_lo = prod_c[XLEN-1:0];
        end
    end

    assign done = busy && (cnt == SHW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            div_mode <= (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            mcand    <= b_mag;
            hi       <= '0;
            lo       <= a_mag;
        end else if (busy) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt + SHW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// alu_md: RISC-V style ALU with iterative multiply/divide.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_valid/o_ready request handshake; i_op, i_Ra, i_Rb captured on it
//   o_valid/i_ready result handshake; o_Rc, o_Z, o_C held until taken
//   o_state         current control state (debug)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds its payload until then, and the receiver may
// raise ready independently of valid.
// Single-cycle ops and the divide fast paths go IDLE->DONE; multiply and
// divide go IDLE->BUSY for XLEN cycles, then DONE.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_Ra,
    input  logic [XLEN-1:0] i_Rb,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_Rc,
    output logic            o_Z,
    output logic            o_C,
    output state_t          o_state
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, next_state;
    logic            accept;
    logic [4:0]      op_q;

    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   sum_ext;
    logic [XLEN-1:0] alu_res;
    logic            alu_c;

    logic            div_op, rem_op, div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    logic            iter_start, iter_done;
    logic [XLEN-1:0] iter_hi, iter_lo, iter_res;

    logic            load;
    logic [XLEN-1:0] load_val;
    logic            load_c;

    assign o_ready = (state == ST_IDLE) && !i_rst;
    assign o_valid = (state == ST_DONE);
    assign o_state = state;
    assign accept  = i_valid && o_ready;
    assign shamt   = i_Rb[SHW-1:0];

    // Single-cycle ALU
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum_ext = '0;
        case (i_op)
            OP_ADD: begin
                sum_ext = {1'b0, i_Ra} + {1'b0, i_Rb};
                alu_res = sum_ext[XLEN-1:0];
                alu_c   = sum_ext[XLEN];
            end
            OP_SUB: begin
                // a + ~b + 1: carry-out is the inverted borrow
                sum_ext = {1'b0, i_Ra} + {1'b0, ~i_Rb} + {{XLEN{1'b0}}, 1'b1};
                alu_res = sum_ext[XLEN-1:0];
                alu_c   = sum_ext[XLEN];
            end
            OP_SLL:  alu_res = i_Ra << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_Ra) < $signed(i_Rb))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (i_Ra < i_Rb)};
            OP_XOR:  alu_res = i_Ra ^ i_Rb;
            OP_SRL:  alu_res = i_Ra >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(i_Ra) >>> shamt);
            OP_OR:   alu_res = i_Ra | i_Rb;
            OP_AND:  alu_res = i_Ra & i_Rb;
            default: alu_res = '0;
        endcase
    end

    // Divide fast paths: divide-by-zero and most-negative / -1
    always_comb begin
        div_op   = (i_op == OP_DIV) || (i_op == OP_DIVU) || (i_op == OP_REM) || (i_op == OP_REMU);
        rem_op   = (i_op == OP_REM) || (i_op == OP_REMU);
        div_zero = div_op && (i_Rb == '0);
        div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_Ra == MOST_NEG) && (i_Rb == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_res = rem_op ? i_Ra : '1;
        end else begin
            fast_res = rem_op ? '0 : i_Ra;
        end
    end

    assign iter_start = accept && is_iter_op(i_op) && !fast;

    muldiv_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_muldiv (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (iter_start),
        .op     (i_op),
        .a      (i_Ra),
        .b      (i_Rb),
        .done   (iter_done),
        .res_hi (iter_hi),
        .res_lo (iter_lo)
    );

    always_comb begin
        case (op_q)
            OP_MUL, OP_DIV, OP_DIVU: iter_res = iter_lo;
            default:                 iter_res = iter_hi;
        endcase
    end

    // Next state and result load
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        load_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (iter_start) begin
                        next_state = ST_BUSY;
                    end else begin
                        next_state = ST_DONE;
                        load       = 1'b1;
                        load_val   = fast ? fast_res : alu_res;
                        load_c     = fast ? 1'b0 : alu_c;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    next_state = ST_DONE;
                    load       = 1'b1;
                    load_val   = iter_res;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            o_Rc  <= '0;
            o_Z   <= 1'b0;
            o_C   <= 1'b0;
            op_q  <= OP_ADD;
        end else begin
            state <= next_state;
            if (load) begin
                o_Rc <= load_val;
                o_Z  <= (load_val == '0);
                o_C  <= load_c;
            end
            if (iter_start) begin
                op_q <= i_op;
            end
        end
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from i_Rb[SHW-1:0].
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_valid  in  1  request valid; i_op/i_Ra/i_Rb sampled when i_valid and o_ready are both high.
REQ-006 o_ready  out  1  block idle, can accept a request.
REQ-007 i_op  in  5  operation code, values in the shared package.
REQ-008 i_Ra, i_Rb  in  XLEN  operands.
REQ-009 o_valid  out  1  result valid; held until consumed.
REQ-010 i_ready  in  1  consumer accepts result when o_valid and i_ready are both high.
REQ-011 o_Rc  out  XLEN  result.
REQ-012 o_Z  out  1  high iff o_Rc == 0, valid with o_valid.
REQ-013 o_C  out  1  carry-out of ADD, inverted borrow of SUB (1 = no borrow); 0 for every other op.

Function
REQ-014 Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (single-cycle class); MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (iterative class), RISC-V semantics at XLEN.
REQ-015 States IDLE, BUSY, DONE; o_ready = 1 only in IDLE; o_valid = 1 only in DONE.
REQ-016 Handshake accepted in cycle t, single-cycle class: IDLE->DONE, o_valid first high in cycle t+1.
REQ-017 Handshake in cycle t, iterative class: IDLE->BUSY, exactly XLEN BUSY cycles (one bit per cycle, shift-add / restoring divide), then DONE; o_valid first high in cycle t+XLEN+1.
REQ-018 Divide-by-zero fast path, latency as REQ-016: DIV/DIVU -> all ones; REM/REMU -> i_Ra.
REQ-019 Signed overflow fast path (DIV/REM, i_Ra = most-negative, i_Rb = all ones), latency as REQ-016: DIV -> i_Ra; REM -> 0.
REQ-020 MULH/MULHSU/MULHU return upper XLEN bits of the 2*XLEN product; MUL returns lower XLEN bits; signed operands handled by sign correction, not wider array.
REQ-021 Shifts use i_Rb[SHW-1:0] only; SRA replicates i_Ra[XLEN-1].
REQ-022 Operands registered at handshake; input changes after acceptance have no effect on the result.
REQ-023 DONE holds o_Rc/o_Z/o_C/o_valid stable while i_ready = 0; on o_valid & i_ready, DONE->IDLE, o_valid low next cycle.
REQ-024 i_valid outside IDLE is ignored; no queuing; undefined op codes complete as single-cycle with o_Rc = 0.

Reset
REQ-025 While i_rst high at an edge: state <= IDLE, o_valid <= 0, o_Rc <= 0, o_Z <= 0, o_C <= 0, iteration counter <= 0; o_ready = 0 while i_rst is high.
REQ-026 Reset in BUSY or DONE aborts the operation; no partial or stale result is ever presented afterwards; o_ready = 1 first cycle after i_rst deasserts.

Structure
REQ-027 Shared package alu_md_pkg holds the 5-bit op codes, the state typedef and the op-class decode function; the bench uses the same package.
REQ-028 Iterative datapath is one sub-module, muldiv_iter (start, op, operands, XLEN-cycle counter, done, hi/lo result); single-cycle ALU and FSM live in alu_md.

Verification
REQ-029 XLEN=32, ADD 0xFFFFFFFF + 0x1 -> o_Rc = 0, o_Z = 1, o_C = 1, o_valid in cycle t+1.
REQ-030 MULH 0x80000000 * 0x80000000 -> 0x40000000; MUL same operands -> 0x0, o_Z = 1; o_valid in cycle t+33.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0x0; both o_valid in cycle t+1.
REQ-032 DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 0x7; DIVU 100 / 7 -> 14, REMU -> 2 in cycle t+33.
REQ-033 o_valid with i_ready = 0 for 5 cycles, i_valid pulsed meanwhile -> o_Rc stable, o_ready = 0, pulsed request ignored; i_ready = 1 -> o_valid low next cycle, o_ready high.
REQ-034 i_rst pulsed 10 cycles into DIVU -> o_valid = 0 throughout, o_ready = 1 after deassert, next ADD 2 + 3 returns 5 in cycle t+1.
